// File: rtl/frame_buffer_if.sv
// Drawing-side and display-side signal bundle for the double-buffered frame store.
// The master side is the drawing/display logic; the slave side is the buffer itself.
interface frame_buffer_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_data;
  logic                  write_ready;
  logic                  swap_request;
  logic                  swap_done;
  logic                  frame_start;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_data;
  logic                  read_valid;
  logic                  front_bank;

  modport master (
    output write_enable, write_addr, write_data, swap_request,
    output frame_start, read_enable, read_addr,
    input  write_ready, swap_done, read_data, read_valid, front_bank
  );

  modport slave (
    input  write_enable, write_addr, write_data, swap_request,
    input  frame_start, read_enable, read_addr,
    output write_ready, swap_done, read_data, read_valid, front_bank
  );
endinterface

// File: rtl/frame_buffer.sv
// Double-buffered 1-bit pixel store: the drawing stage fills the back bank while
// the display reads the front bank; banks swap only on a display frame boundary.
module frame_buffer #(
  parameter int PIXELS_COUNT = 5,
  parameter int ADDR_WIDTH   = $clog2(PIXELS_COUNT)
) (
  input logic           clk,
  input logic           rst,
  frame_buffer_if.slave bus
);

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

  localparam logic [ADDR_WIDTH:0] PIXEL_LIMIT = (ADDR_WIDTH + 1)'(PIXELS_COUNT);

  swap_state_t             state;
  logic                    front_q;
  logic                    write_ready_q;
  logic                    swap_done_q;
  logic                    read_data_q;
  logic                    read_valid_q;
  logic [PIXELS_COUNT-1:0] bank0;
  logic [PIXELS_COUNT-1:0] bank1;
  logic                    write_in_range;
  logic                    read_in_range;
  logic                    front_pixel;

  assign write_in_range = ({1'b0, bus.write_addr} < PIXEL_LIMIT);
  assign read_in_range  = ({1'b0, bus.read_addr} < PIXEL_LIMIT);

  assign bus.write_ready = write_ready_q;
  assign bus.swap_done   = swap_done_q;
  assign bus.read_data   = read_data_q;
  assign bus.read_valid  = read_valid_q;
  assign bus.front_bank  = front_q;

  // Swap FSM: a swap can only land on a frame_start edge; write_ready is its registered IDLE flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      front_q       <= 1'b0;
      write_ready_q <= 1'b1;
      swap_done_q   <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.swap_request) begin
            if (bus.frame_start) begin
              front_q     <= ~front_q;
              swap_done_q <= 1'b1;
            end else begin
              state         <= PENDING;
              write_ready_q <= 1'b0;
            end
          end
        end
        PENDING: begin
          if (bus.frame_start) begin
            front_q       <= ~front_q;
            swap_done_q   <= 1'b1;
            state         <= IDLE;
            write_ready_q <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          write_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Back-bank write; uses the pre-swap bank selection and is never cleared, even by reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.write_enable && write_ready_q && write_in_range) begin
      if (front_q) begin
        bank0[bus.write_addr] <= bus.write_data;
      end else begin
        bank1[bus.write_addr] <= bus.write_data;
      end
    end
  end

  // Front-bank pixel lookup; out-of-range addresses read as 0.
  always_comb begin
    front_pixel = 1'b0;
    if (read_in_range) begin
      front_pixel = front_q ? bank1[bus.read_addr] : bank0[bus.read_addr];
    end
  end

  // One-cycle registered read port; read_data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= 1'b0;
      read_valid_q <= 1'b0;
    end else if (bus.read_enable) begin
      read_data_q  <= front_pixel;
      read_valid_q <= 1'b1;
    end else begin
      read_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
- REQ-001: The block SHALL have a parameter PIXELS_COUNT, default 5: number of 1-bit pixels per bank.
- REQ-002: The block SHALL have a parameter ADDR_WIDTH, default $clog2(PIXELS_COUNT): pixel address width.
- REQ-003: The block SHALL have a single clock and a synchronous, active-high reset, as follows.
  - clk  in  1  single clock; all state updates on its rising edge.
  - rst  in  1  synchronous, active-high reset.
- REQ-004: The block SHALL have the following drawing-side ports.
  - write_enable  in  1  pixel write strobe from the drawing stage.
  - write_addr  in  ADDR_WIDTH  pixel address of the write.
  - write_data  in  1  pixel value of the write.
  - write_ready  out  1  high when writes are accepted (no swap pending).
  - swap_request  in  1  drawing side signals that the back bank is complete.
  - swap_done  out  1  one-cycle pulse: the swap has taken effect.
- REQ-005: The block SHALL have the following display-side ports.
  - frame_start  in  1  display frame boundary; the only instant a swap may occur.
  - read_enable  in  1  display read strobe.
  - read_addr  in  ADDR_WIDTH  pixel address of the read.
  - read_data  out  1  registered pixel value from the front bank.
  - read_valid  out  1  read_data is valid this cycle.
  - front_bank  out  1  index (0/1) of the bank currently displayed.

Function
- REQ-006: The block SHALL hold two banks of PIXELS_COUNT bits each.
  - The front bank is selected by front_bank; the back bank is the other one.
- REQ-007: When write_enable=1, write_ready=1 and write_addr<PIXELS_COUNT, the block SHALL store write_data into the back bank at write_addr at that clock edge.
  - All other writes SHALL be dropped with no side effect.
- REQ-008: When read_enable=1, the block SHALL drive the front-bank bit at read_addr on read_data at the next cycle, with read_valid=1.
  - Read latency is exactly 1 cycle; back-to-back reads are supported every cycle.
- REQ-009: A read with read_addr>=PIXELS_COUNT SHALL return read_data=0 with read_valid=1.
- REQ-010: When read_enable=0, read_valid SHALL be 0 next cycle and read_data SHALL hold its previous value.
- REQ-011: The swap FSM SHALL have two states, IDLE and PENDING; write_ready = (state==IDLE).
- REQ-012: IDLE transitions:
  - swap_request=1 and frame_start=0 -> PENDING.
  - swap_request=1 and frame_start=1 -> swap at this edge, remain IDLE.
- REQ-013: PENDING transitions:
  - frame_start=1 -> swap at this edge, go to IDLE.
  - swap_request in PENDING SHALL be ignored.
- REQ-014: A swap SHALL invert front_bank, and SHALL assert swap_done for exactly the one cycle following the swap edge.
- REQ-015: Same-edge rule: a write or read in the cycle of a swap edge SHALL use the pre-swap bank selection.
- REQ-016: frame_start in IDLE without swap_request SHALL have no effect.
- REQ-017: Bank contents SHALL never be cleared by the block; clearing is the drawing stage's job.

Reset
- REQ-018: While rst=1 at an edge, the block SHALL set:
  - state=IDLE, front_bank=0, write_ready=1 (after the edge);
  - swap_done=0, read_valid=0, read_data=0.
- REQ-019: rst SHALL override all other inputs in the same cycle.
  - Writes, reads and swap requests in that cycle are discarded.
- REQ-020: Reset mid-PENDING SHALL abandon the swap (front_bank=0, no swap_done).
- REQ-021: Bank contents SHALL be unaffected by reset.

Verification
- REQ-022: The bench SHALL cover the following directed scenarios (PIXELS_COUNT=5):
  - Basic write/read: after reset, write 1 to addresses 0..4, pulse swap_request with frame_start=1 the same cycle -> swap_done pulses next cycle; front_bank=1; reads of 0..4 return 1 one cycle after each read_enable.
  - Pending swap: swap_request with frame_start=0 -> write_ready=0; a write to address 2 during PENDING is dropped; frame_start 3 cycles later -> front_bank toggles, write_ready=1, single swap_done pulse.
  - Out-of-range: write to address 6 -> no bank changes; read address 7 -> read_data=0, read_valid=1.
  - Same-edge: a read issued on the swap edge returns the old front bank's pixel.
  - Reset mid-PENDING: rst -> front_bank=0, write_ready=1, no swap_done; previously written pixels still readable.
  - Throughput: continuous read_enable over 5 addresses -> read_valid high for 5 consecutive cycles with correct data.
